// File: rtl/riscv_pkg.sv
// Shared types for the instruction fetch unit: reset vector, fetch FSM states
// and the {instr, pc} entry carried through the prefetch FIFO.
package riscv_pkg;

    localparam int              XLEN         = 32;
    localparam logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        HALT
    } ifu_state_e;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/ifu_fifo.sv
// Synchronous prefetch FIFO of fetch entries with flush; flush wins over push/pop.
// A push into a full FIFO without a simultaneous pop is a credit-protocol error.
module ifu_fifo
    import riscv_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       push,
    input  fetch_entry_t               wdata,
    input  logic                       pop,
    output fetch_entry_t               head,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; pointers and count alone define validity.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    overflow_a: assert property (@(posedge clk) disable iff (reset || flush)
                                 !(push && full && !pop));

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues credit-limited imem reads, buffers
// returns in a prefetch FIFO and handles redirects. Optional trap: IFU_MISALIGN_TRAP_EN.
module instr_fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC        = RESET_VECTOR,
    parameter int          FIFO_DEPTH      = 2,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pcsrc,
    input  logic [31:0] pctarget,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic        misalign
);

    localparam int CW = $clog2(MAX_OUTSTANDING + 1);

    ifu_state_e                      state_q, state_d;
    logic [31:0]                     fetch_pc;
    logic [31:0]                     resp_pc;
    logic [CW-1:0]                   outstanding, outstanding_nxt;
    logic [CW-1:0]                   kill;
    logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count;
    logic                            fifo_empty;
    logic                            fifo_full;
    fetch_entry_t                    fifo_head;
    logic                            has_credit;
    logic                            issue;
    logic                            push;
    logic                            bad_redirect;
    logic [31:0]                     load_target;

`ifdef IFU_MISALIGN_TRAP_EN
    assign bad_redirect = pcsrc & (pctarget[1:0] != 2'b00);
    assign load_target  = pctarget;

    always_ff @(posedge clk) begin
        if (reset)      misalign <= 1'b0;
        else if (pcsrc) misalign <= bad_redirect;
    end
`else
    logic unused_target_lsbs;
    assign unused_target_lsbs = ^pctarget[1:0];
    assign bad_redirect       = 1'b0;
    assign load_target        = {pctarget[31:2], 2'b00};
    assign misalign           = 1'b0;
`endif

    // Sum of in-flight requests and buffered words may never exceed the FIFO depth,
    // so every response is guaranteed a slot.
    assign has_credit = (int'(outstanding) + int'(fifo_count) < FIFO_DEPTH) &&
                        (int'(outstanding) < MAX_OUTSTANDING);
    assign issue      = imem_req & imem_gnt;
    assign imem_addr  = fetch_pc;
    assign push       = imem_rvalid & (kill == '0);

    // NOTE: combinational processes assign every output a default first, so no latch can form.
    always_comb begin
        state_d  = state_q;
        imem_req = 1'b0;
        unique case (state_q)
            BOOT: state_d = RUN;
            RUN: begin
                imem_req = has_credit;
                if (bad_redirect) state_d = HALT;
            end
            HALT:    if (pcsrc && !bad_redirect) state_d = RUN;
            default: state_d = BOOT;
        endcase
    end

    always_comb begin
        outstanding_nxt = outstanding;
        if (issue && !imem_rvalid)      outstanding_nxt = outstanding + CW'(1);
        else if (!issue && imem_rvalid) outstanding_nxt = outstanding - CW'(1);
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= BOOT;
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            kill        <= '0;
        end else begin
            state_q     <= state_d;
            outstanding <= outstanding_nxt;
            if (pcsrc) begin
                // Everything still in flight after this edge belongs to the old stream.
                fetch_pc <= load_target;
                resp_pc  <= load_target;
                kill     <= outstanding_nxt;
            end else begin
                if (issue) fetch_pc <= fetch_pc + 32'd4;
                if (imem_rvalid) begin
                    if (kill != '0) kill    <= kill - CW'(1);
                    else            resp_pc <= resp_pc + 32'd4;
                end
            end
        end
    end

    ifu_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (pcsrc),
        .push  (push),
        .wdata ('{instr: imem_rdata, pc: resp_pc}),
        .pop   (if_valid & if_ready),
        .head  (fifo_head),
        .count (fifo_count),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign if_valid = ~fifo_empty;
    assign instr    = if_valid ? fifo_head.instr : 32'h0;
    assign pc       = if_valid ? fifo_head.pc    : 32'h0;

    logic unused_fifo_full;
    assign unused_fifo_full = fifo_full;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: a 1-cycle-latency in-order memory model
// records granted addresses; expected {pc, instr} pairs are checked on consumption.
module tb_instr_fetch_unit;

    localparam int FIFO_DEPTH = 2;

    logic        clk;
    logic        reset;
    logic        pcsrc;
    logic [31:0] pctarget;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        if_valid;
    logic        if_ready;
    logic        misalign;

    int          checks;
    int          errors;
    int          consumed;
    logic [31:0] last_pc;
    logic [31:0] last_instr;
    logic [31:0] last_gnt_addr;
    bit          gnt_en;
    bit          ready_en;
    bit          rsp_hold;
    logic [31:0] resp_q[$];
    logic [63:0] exp_q[$];

    instr_fetch_unit #(
        .RESET_PC        (32'h0000_0000),
        .FIFO_DEPTH      (FIFO_DEPTH),
        .MAX_OUTSTANDING (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pcsrc       (pcsrc),
        .pctarget    (pctarget),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .pc          (pc),
        .if_valid    (if_valid),
        .if_ready    (if_ready),
        .misalign    (misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h00e0_0093;
            32'h0000_0004: return 32'h3e80_0113;
            default:       return {a[15:0], ~a[15:0]} ^ 32'h1357_9bdf;
        endcase
    endfunction

    // Called at a falling edge: drive inputs for the next rising edge, log the
    // handshakes that edge will complete, then advance to the next falling edge.
    task automatic tick(input bit redir = 1'b0, input logic [31:0] tgt = 32'h0);
        logic [63:0] e;
        imem_rvalid = !reset && !rsp_hold && (resp_q.size() > 0);
        imem_rdata  = imem_rvalid ? mem_word(resp_q[0]) : 32'h0;
        imem_gnt    = gnt_en;
        if_ready    = ready_en;
        pcsrc       = redir;
        pctarget    = tgt;
        if (reset) begin
            resp_q.delete();
            exp_q.delete();
        end else begin
            if (if_valid && if_ready) begin
                consumed++;
                last_pc    = pc;
                last_instr = instr;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL out_unexpected got pc=%h instr=%h, expected no output", pc, instr);
                end else begin
                    e = exp_q.pop_front();
                    if ({pc, instr} !== e) begin
                        errors++;
                        $display("FAIL out_seq got pc=%h instr=%h, expected pc=%h instr=%h",
                                 pc, instr, e[63:32], e[31:0]);
                    end
                end
            end
            if (imem_rvalid) resp_q.delete(0);
            if (imem_req && imem_gnt) begin
                resp_q.push_back(imem_addr);
                exp_q.push_back({imem_addr, mem_word(imem_addr)});
                last_gnt_addr = imem_addr;
            end
            if (redir) exp_q.delete();
        end
        @(posedge clk);
        @(negedge clk);
        pcsrc = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        gnt_en   = 1'b0;
        ready_en = 1'b0;
        rsp_hold = 1'b0;
        ticks(2);
        reset    = 1'b0;
        consumed = 0;
    endtask

    task automatic wait_out(input string name);
        int start;
        start = consumed;
        for (int i = 0; i < 30 && consumed == start; i++) tick();
        if (consumed == start) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout got no output in 30 cycles, expected one", name);
        end
    endtask

    task automatic check_pc(input string name, input logic [31:0] exp);
        checks++;
        if (last_pc !== exp) begin
            errors++;
            $display("FAIL %s got pc=%h, expected %h", name, last_pc, exp);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        ticks(2);
        checks++;
        if ({imem_req, if_valid, misalign, instr, pc} !== 67'h0) begin
            errors++;
            $display("FAIL reset_outputs got req=%b valid=%b mis=%b instr=%h pc=%h, expected all 0",
                     imem_req, if_valid, misalign, instr, pc);
        end
        reset = 1'b0;
        checks++;
        if (imem_req !== 1'b0 || if_valid !== 1'b0) begin
            errors++;
            $display("FAIL boot_cycle got req=%b valid=%b, expected 0 0", imem_req, if_valid);
        end
    endtask

    task automatic test_stream();
        int c0;
        do_reset();
        gnt_en   = 1'b1;
        ready_en = 1'b1;
        tick();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            errors++;
            $display("FAIL first_req got req=%b addr=%h, expected 1 00000000", imem_req, imem_addr);
        end
        wait_out("stream0");
        check_pc("stream0_pc", 32'h0);
        checks++;
        if (last_instr !== 32'h00e0_0093) begin
            errors++;
            $display("FAIL stream0_instr got %h, expected 00e00093", last_instr);
        end
        wait_out("stream1");
        check_pc("stream1_pc", 32'h4);
        checks++;
        if (last_instr !== 32'h3e80_0113) begin
            errors++;
            $display("FAIL stream1_instr got %h, expected 3e800113", last_instr);
        end
        c0 = consumed;
        ticks(30);
        checks++;
        if (consumed - c0 < 15) begin
            errors++;
            $display("FAIL stream_rate got %0d outputs in 30 cycles, expected at least 15", consumed - c0);
        end
    endtask

    task automatic test_backpressure();
        int c0;
        do_reset();
        gnt_en   = 1'b1;
        ready_en = 1'b1;
        ticks(6);
        ready_en = 1'b0;
        ticks(10);
        checks++;
        if (exp_q.size() != FIFO_DEPTH || imem_req !== 1'b0 || if_valid !== 1'b1) begin
            errors++;
            $display("FAIL stall_fill got buffered=%0d req=%b valid=%b, expected %0d 0 1",
                     exp_q.size(), imem_req, if_valid, FIFO_DEPTH);
        end
        ready_en = 1'b1;
        c0 = consumed;
        ticks(10);
        checks++;
        if (consumed - c0 < FIFO_DEPTH) begin
            errors++;
            $display("FAIL stall_resume got %0d outputs, expected at least %0d", consumed - c0, FIFO_DEPTH);
        end
    endtask

    task automatic test_redirect_inflight();
        do_reset();
        gnt_en   = 1'b1;
        ready_en = 1'b1;
        ticks(4);
        rsp_hold = 1'b1;
        ticks(4);
        checks++;
        if (resp_q.size() != 2 || imem_req !== 1'b0) begin
            errors++;
            $display("FAIL inflight got outstanding=%0d req=%b, expected 2 0", resp_q.size(), imem_req);
        end
        tick(1'b1, 32'h0000_0100);
        rsp_hold = 1'b0;
        wait_out("redirect");
        check_pc("redirect_pc", 32'h0000_0100);
        ticks(6);
    endtask

    task automatic test_gnt_stall();
        logic [31:0] held;
        do_reset();
        gnt_en   = 1'b1;
        ready_en = 1'b1;
        ticks(5);
        gnt_en = 1'b0;
        ticks(3);
        held = last_gnt_addr + 32'd4;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== held) begin
                errors++;
                $display("FAIL gnt_hold cycle %0d got req=%b addr=%h, expected 1 %h",
                         i, imem_req, imem_addr, held);
            end
            tick();
        end
        checks++;
        if (if_valid !== 1'b0) begin
            errors++;
            $display("FAIL gnt_drain got valid=%b, expected 0", if_valid);
        end
        gnt_en = 1'b1;
        wait_out("gnt_resume");
        check_pc("gnt_resume_pc", held);
    endtask

    task automatic test_wrap();
        do_reset();
        gnt_en   = 1'b1;
        ready_en = 1'b1;
        ticks(3);
        tick(1'b1, 32'hFFFF_FFFC);
        wait_out("wrap0");
        check_pc("wrap0_pc", 32'hFFFF_FFFC);
        wait_out("wrap1");
        check_pc("wrap1_pc", 32'h0000_0000);
    endtask

    task automatic test_misalign();
        bit req_seen;
        do_reset();
        gnt_en   = 1'b1;
        ready_en = 1'b1;
        ticks(3);
        tick(1'b1, 32'h0000_0102);
`ifdef IFU_MISALIGN_TRAP_EN
        req_seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (imem_req !== 1'b0 || if_valid !== 1'b0) req_seen = 1'b1;
            tick();
        end
        checks++;
        if (misalign !== 1'b1 || req_seen) begin
            errors++;
            $display("FAIL misalign_halt got mis=%b req_or_valid_seen=%b, expected 1 0", misalign, req_seen);
        end
        tick(1'b1, 32'h0000_0200);
        checks++;
        if (misalign !== 1'b0) begin
            errors++;
            $display("FAIL misalign_clear got %b, expected 0", misalign);
        end
        wait_out("misalign_resume");
        check_pc("misalign_resume_pc", 32'h0000_0200);
`else
        req_seen = 1'b0;
        checks++;
        if (misalign !== 1'b0) begin
            errors++;
            $display("FAIL misalign_tied got %b, expected 0", misalign);
        end
        wait_out("align_force");
        check_pc("align_force_pc", 32'h0000_0100);
        if (req_seen) $display("unexpected state");
`endif
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        consumed    = 0;
        last_pc     = '0;
        last_instr  = '0;
        last_gnt_addr = '0;
        reset       = 1'b1;
        pcsrc       = 1'b0;
        pctarget    = '0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        if_ready    = 1'b0;
        gnt_en      = 1'b0;
        ready_en    = 1'b0;
        rsp_hold    = 1'b0;
        @(negedge clk);
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_inflight();
        test_gnt_stall();
        test_wrap();
        test_misalign();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
